// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter sharing one spi_master between NREQ requesters; shadows the master's byte sequence.
// Latency: gnt one cycle after an IDLE sample of req, done 11 cycles after that; one transfer per 12 cycles.
// Backpressure: req is a held level, sampled only in IDLE; losers and late arrivals simply wait.
module spi_txn_arbiter #(
    parameter int NREQ = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*8-1:0]         req_data,
    input  logic [NREQ*2-1:0]         req_mode,
    input  logic [NREQ*2-1:0]         req_cs,
    output logic [NREQ-1:0]           gnt,
    output logic [NREQ-1:0]           done,
    output logic                      busy,
    output logic [$clog2(NREQ)-1:0]   owner,
    output logic                      load_m,
    output logic [7:0]                data,
    output logic [1:0]                mode,
    output logic [1:0]                chip_sel
);
    localparam int IW = $clog2(NREQ);

    typedef enum logic [2:0] {IDLE, ISSUE, LOADW, XFER, DONE} state_t;

    state_t         state;
    state_t         state_nxt;
    logic [IW-1:0]  ptr;
    logic [2:0]     cnt;
    logic [IW-1:0]  win;
    logic           win_vld;
    logic [7:0]     sel_data;
    logic [1:0]     sel_mode;
    logic [1:0]     sel_cs;

    // Scan upward from ptr with wrap; the first requester found wins.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!win_vld && req[idx]) begin
                win_vld = 1'b1;
                win     = IW'(idx);
            end
        end
    end

    always_comb begin
        sel_data = '0;
        sel_mode = '0;
        sel_cs   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == IW'(i)) begin
                sel_data = req_data[8*i +: 8];
                sel_mode = req_mode[2*i +: 2];
                sel_cs   = req_cs[2*i +: 2];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_vld) state_nxt = ISSUE;
            ISSUE:   state_nxt = LOADW;
            LOADW:   state_nxt = XFER;
            XFER:    if (cnt == 3'd7) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gnt    = '0;
        done   = '0;
        load_m = (state == ISSUE);
        busy   = (state != IDLE);
        if (state == ISSUE) gnt[owner]  = 1'b1;
        if (state == DONE)  done[owner] = 1'b1;
    end

    // Operands stay put in IDLE so the master's idle sclk polarity never glitches.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr      <= '0;
            cnt      <= '0;
            owner    <= '0;
            data     <= '0;
            mode     <= '0;
            chip_sel <= '0;
        end else begin
            case (state)
                IDLE: if (win_vld) begin
                    owner    <= win;
                    data     <= sel_data;
                    mode     <= sel_mode;
                    chip_sel <= sel_cs;
                    ptr      <= (win == IW'(NREQ - 1)) ? '0 : win + IW'(1);
                end
                LOADW:   cnt <= '0;
                XFER:    cnt <= cnt + 3'd1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Randomized bench for spi_txn_arbiter against a transaction-timeline reference model.
module tb_spi_txn_arbiter;
    localparam int NREQ = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [7:0]  req_mode;
    logic [7:0]  req_cs;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        busy;
    logic [1:0]  owner;
    logic        load_m;
    logic [7:0]  data;
    logic [1:0]  mode;
    logic [1:0]  chip_sel;

    spi_txn_arbiter #(.NREQ(NREQ)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_mode(req_mode),
        .req_cs(req_cs), .gnt(gnt), .done(done), .busy(busy), .owner(owner),
        .load_m(load_m), .data(data), .mode(mode), .chip_sel(chip_sel)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Staged operands for the next cycle
    logic [31:0] s_data;
    logic [7:0]  s_mode;
    logic [7:0]  s_cs;

    // Reference model: who owns the current transfer and when it started
    int          m_ptr = 0;
    int          m_start = 0;
    int          m_free = 0;
    bit          m_active = 0;
    int          m_owner = 0;
    logic [7:0]  m_data = '0;
    logic [1:0]  m_mode = '0;
    logic [1:0]  m_cs = '0;

    logic [3:0]  e_gnt = '0;
    logic [3:0]  e_done = '0;
    logic        e_busy = 1'b0;
    logic        e_load = 1'b0;

    int glog[$];
    int dlog[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int at(input int q[$], input int i);
        return (q.size() > i) ? q[i] : -1;
    endfunction

    task automatic rand_ops();
        s_data = $urandom;
        s_mode = 8'($urandom);
        s_cs   = 8'($urandom);
    endtask

    // Compare the current cycle, drive the next one, advance the model.
    task automatic tick(input logic r, input logic [3:0] q);
        int d;
        @(negedge clk);
        chk("gnt", 32'(gnt), 32'(e_gnt));
        chk("done", 32'(done), 32'(e_done));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("load_m", 32'(load_m), 32'(e_load));
        chk("owner", 32'(owner), 32'(m_owner));
        chk("data", 32'(data), 32'(m_data));
        chk("mode", 32'(mode), 32'(m_mode));
        chk("chip_sel", 32'(chip_sel), 32'(m_cs));
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i])  glog.push_back(i);
            if (done[i]) dlog.push_back(i);
        end
        rst = r; req = q;
        req_data = s_data; req_mode = s_mode; req_cs = s_cs;
        if (!r) begin
            m_ptr = 0; m_active = 0; m_free = cyc + 1;
            m_owner = 0; m_data = '0; m_mode = '0; m_cs = '0;
        end else if (cyc >= m_free && q != 0) begin
            int w;
            bit f;
            w = 0; f = 0;
            for (int k = 0; k < NREQ; k++) begin
                int i;
                i = (m_ptr + k) % NREQ;
                if (!f && q[i]) begin f = 1; w = i; end
            end
            m_owner = w;
            m_data = s_data[8*w +: 8];
            m_mode = s_mode[2*w +: 2];
            m_cs   = s_cs[2*w +: 2];
            m_ptr  = (w + 1) % NREQ;
            m_start = cyc; m_free = cyc + 12; m_active = 1;
        end
        d = cyc + 1 - m_start;
        e_busy = m_active && d >= 1 && d <= 11;
        e_load = m_active && d == 1;
        e_gnt  = (m_active && d == 1)  ? 4'(1 << m_owner) : 4'h0;
        e_done = (m_active && d == 11) ? 4'(1 << m_owner) : 4'h0;
        cyc++;
    endtask

    initial begin
        rst = 1'b0; req = '0; req_data = '0; req_mode = '0; req_cs = '0;
        s_data = '0; s_mode = '0; s_cs = '0;
        tick(1'b0, 4'h0);
        tick(1'b0, 4'h0);

        // All requesting from ptr=0: 0,1,2,3,0 with done in the same order
        glog.delete(); dlog.delete();
        for (int j = 0; j < 60; j++) begin rand_ops(); tick(1'b1, 4'hF); end
        tick(1'b1, 4'h0);
        for (int j = 0; j < 5; j++) begin
            chk("all_gnt_order", 32'(at(glog, j)), 32'((j == 4) ? 0 : j));
            chk("all_done_order", 32'(at(dlog, j)), 32'((j == 4) ? 0 : j));
        end

        // Pointer wrap: grant 3, then 1001 must give 0 before 3
        rand_ops(); tick(1'b1, 4'b1000);
        for (int j = 0; j < 11; j++) begin rand_ops(); tick(1'b1, 4'h0); end
        glog.delete();
        for (int j = 0; j < 24; j++) begin rand_ops(); tick(1'b1, 4'b1001); end
        for (int j = 0; j < 14; j++) begin rand_ops(); tick(1'b1, 4'h0); end
        chk("wrap_first", 32'(at(glog, 0)), 32'd0);
        chk("wrap_second", 32'(at(glog, 1)), 32'd3);

        // Single transfer of A5 from requester 2; operands churn afterwards
        rand_ops();
        s_data[23:16] = 8'hA5; s_mode[5:4] = 2'b01; s_cs[5:4] = 2'b10;
        tick(1'b1, 4'b0100);
        for (int j = 0; j < 13; j++) begin
            rand_ops(); tick(1'b1, 4'h0);
            if (j == 5) begin
                chk("a5_data", 32'(data), 32'h0000_00A5);
                chk("a5_mode", 32'(mode), 32'd1);
                chk("a5_cs", 32'(chip_sel), 32'd2);
            end
        end

        // Late request: req[1] rises during requester 0's XFER
        glog.delete();
        rand_ops(); tick(1'b1, 4'b0001);
        for (int j = 0; j < 3; j++) begin rand_ops(); tick(1'b1, 4'h0); end
        for (int j = 0; j < 20; j++) begin rand_ops(); tick(1'b1, 4'b0010); end
        for (int j = 0; j < 12; j++) begin rand_ops(); tick(1'b1, 4'h0); end
        chk("late_first", 32'(at(glog, 0)), 32'd0);
        chk("late_second", 32'(at(glog, 1)), 32'd1);

        // Reset at t+6 aborts; afterwards 1010 goes to requester 1
        dlog.delete(); glog.delete();
        rand_ops(); tick(1'b1, 4'b0100);
        for (int j = 0; j < 5; j++) begin rand_ops(); tick(1'b1, 4'h0); end
        rand_ops(); tick(1'b0, 4'h0);
        rand_ops(); tick(1'b1, 4'b1010);
        for (int j = 0; j < 13; j++) begin rand_ops(); tick(1'b1, 4'h0); end
        chk("rst_abort_done", 32'(at(dlog, 0)), 32'd1);
        chk("rst_regrant", 32'(at(glog, 1)), 32'd1);

        // Random traffic with occasional resets
        for (int j = 0; j < 800; j++) begin
            logic [3:0] q;
            q = ($urandom_range(0, 9) < 3) ? 4'h0 : 4'($urandom);
            rand_ops();
            tick(($urandom_range(0, 149) != 0), q);
        end
        tick(1'b1, 4'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
